// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction-fetch stage.
package fetch_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned INSTR_W = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [INSTR_W-1:0] data;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding fetched {pc, data} pairs for decode.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  fetch_entry_t     entry_i,
   input  logic             pop_i,
   input  logic             flush_i,
   output logic [CNT_W-1:0] count_o,
   output fetch_entry_t     head_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   fetch_entry_t     slot_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
   endfunction

   // Flush wins over push and pop in the same cycle.
   always_comb begin
      do_push  = push_i & ~flush_i;
      do_pop   = pop_i & ~flush_i & (count_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) slot_q[wr_ptr_q] <= entry_i;
   end

   assign count_o = count_q;
   assign head_o  = slot_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues word reads to instruction memory and
// delivers {pc, instr} to decode, with redirect flush and backpressure.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned     ADDR_W    = 10,
   parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int unsigned     BUF_DEPTH = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                fetch_enable,
   input  logic                redirect_valid,
   input  logic [XLEN-1:0]     redirect_pc,
   output logic [ADDR_W-1:0]   mem_address,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [3:0]          mem_byteenable,
   output logic                mem_clken,
   input  logic [INSTR_W-1:0]  mem_readdata,
   output logic                instr_valid,
   output logic [INSTR_W-1:0]  instr_data,
   output logic [XLEN-1:0]     instr_pc,
   input  logic                instr_ready
);

   localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

   logic [1:0]       rst_sync_q;
   logic             rst_n;
   fetch_state_e     state_q, state_d;
   logic [XLEN-1:0]  pc_q, pc_d;
   logic [XLEN-1:0]  pc_inflight_q, pc_inflight_d;
   logic             inflight_q, inflight_d;
   logic             issue_c, push_c, flush_c, pop_c, room_c;
   logic [CNT_W-1:0] buf_count;
   fetch_entry_t     buf_head, buf_entry;

   // Reset asserts asynchronously, releases two edges after reset_n rises.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rst_sync_q <= '0;
      else          rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   assign pop_c  = instr_valid & instr_ready;
   assign room_c = (32'(buf_count) + 32'(inflight_q)) < (BUF_DEPTH + 32'(pop_c));

   always_comb begin
      state_d       = fetch_enable ? FETCH : IDLE;
      pc_d          = pc_q;
      pc_inflight_d = pc_inflight_q;
      inflight_d    = 1'b0;
      issue_c       = 1'b0;
      flush_c       = 1'b0;
      push_c        = 1'b0;
      if (redirect_valid) begin
         // Outside FETCH nothing is in flight, so only the PC moves.
         pc_d    = redirect_pc & ~XLEN'(3);
         flush_c = (state_q == FETCH);
         push_c  = inflight_q & ~flush_c;
      end else begin
         push_c = inflight_q;
         if ((state_q == FETCH) && fetch_enable && room_c) begin
            issue_c       = 1'b1;
            inflight_d    = 1'b1;
            pc_inflight_d = pc_q;
            pc_d          = pc_q + XLEN'(4);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         pc_inflight_q <= RESET_PC;
         inflight_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         pc_inflight_q <= pc_inflight_d;
         inflight_q    <= inflight_d;
      end
   end

   assign buf_entry = '{pc: pc_inflight_q, data: mem_readdata};

   fetch_buffer #(
      .DEPTH (BUF_DEPTH)
   ) u_buffer (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push_c),
      .entry_i (buf_entry),
      .pop_i   (pop_c),
      .flush_i (flush_c),
      .count_o (buf_count),
      .head_o  (buf_head)
   );

   assign mem_address    = pc_q[ADDR_W+1:2];
   assign mem_chipselect = issue_c;
   assign mem_write      = 1'b0;
   assign mem_byteenable = 4'hF;
   assign mem_clken      = 1'b1;

   assign instr_valid = (buf_count != '0);
   assign instr_data  = buf_head.data;
   assign instr_pc    = buf_head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised and directed bench for instr_fetch_unit against a queue-based model.
module tb_instr_fetch_unit;

   localparam int unsigned ADDR_W    = 10;
   localparam int unsigned BUF_DEPTH = 2;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        fetch_enable;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [9:0]  mem_address;
   logic        mem_chipselect;
   logic        mem_write;
   logic [3:0]  mem_byteenable;
   logic        mem_clken;
   logic [31:0] mem_readdata;
   logic        instr_valid;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;
   logic        instr_ready;

   always #5 clk = ~clk;

   instr_fetch_unit #(
      .ADDR_W    (ADDR_W),
      .RESET_PC  (RESET_PC),
      .BUF_DEPTH (BUF_DEPTH)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .fetch_enable   (fetch_enable),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .mem_address    (mem_address),
      .mem_chipselect (mem_chipselect),
      .mem_write      (mem_write),
      .mem_byteenable (mem_byteenable),
      .mem_clken      (mem_clken),
      .mem_readdata   (mem_readdata),
      .instr_valid    (instr_valid),
      .instr_data     (instr_data),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready)
   );

   // Instruction memory: one-cycle read latency, junk when not selected.
   logic [31:0] mem [1024];
   always @(posedge clk) mem_readdata <= mem_chipselect ? mem[mem_address] : $urandom();

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: fetched-but-undelivered PCs in a queue, plus the pending word.
   logic [31:0] m_q [$];
   bit          m_fetch, m_infl;
   logic [31:0] m_pc, m_infl_pc;
   int          m_rst_cnt;

   logic [31:0] got_pc [$];
   logic [31:0] got_data [$];
   logic [31:0] got_addr [$];
   int          got_cs_cyc [$];
   int          got_v_cyc [$];

   always @(negedge clk) begin : compare
      bit          ev, pop, iss;
      logic [31:0] hp;
      int          occ;
      if (!reset_n) begin
         m_q.delete();
         m_fetch   = 1'b0;
         m_infl    = 1'b0;
         m_pc      = RESET_PC;
         m_rst_cnt = 2;
      end
      ev  = (m_q.size() != 0);
      hp  = ev ? m_q[0] : 32'h0;
      pop = ev && instr_ready;
      occ = m_q.size() + int'(m_infl) - int'(pop);
      iss = (m_rst_cnt == 0) && m_fetch && fetch_enable && !redirect_valid && (occ < BUF_DEPTH);

      chk("instr_valid", 32'(instr_valid), 32'(ev));
      chk("mem_chipselect", 32'(mem_chipselect), 32'(iss));
      chk("mem_write", 32'(mem_write), 32'h0);
      chk("mem_byteenable", 32'(mem_byteenable), 32'hF);
      chk("mem_clken", 32'(mem_clken), 32'h1);
      if (ev) begin
         chk("instr_pc", instr_pc, hp);
         chk("instr_data", instr_data, mem[hp[11:2]]);
      end
      if (iss) chk("mem_address", 32'(mem_address), 32'(m_pc[11:2]));

      if (instr_valid && instr_ready) begin
         got_pc.push_back(instr_pc);
         got_data.push_back(instr_data);
      end
      if (instr_valid) got_v_cyc.push_back(cyc);
      if (mem_chipselect) begin
         got_addr.push_back(32'(mem_address));
         got_cs_cyc.push_back(cyc);
      end

      if (!reset_n) begin
      end else if (m_rst_cnt > 0) begin
         m_rst_cnt--;
      end else if (redirect_valid) begin
         m_pc = redirect_pc & 32'hFFFF_FFFC;
         if (m_fetch) begin
            m_q.delete();
         end else begin
            if (pop) void'(m_q.pop_front());
            if (m_infl) m_q.push_back(m_infl_pc);
         end
         m_infl  = 1'b0;
         m_fetch = fetch_enable;
      end else begin
         if (pop) void'(m_q.pop_front());
         if (m_infl) m_q.push_back(m_infl_pc);
         if (iss) begin
            m_infl_pc = m_pc;
            m_pc      = m_pc + 32'd4;
         end
         m_infl  = iss;
         m_fetch = fetch_enable;
      end
      cyc++;
   end

   function automatic logic [31:0] at(input logic [31:0] q [$], input int i);
      if (i < q.size()) return q[i];
      return 32'hDEAD_BEEF;
   endfunction

   function automatic int gaps();
      int n = 0;
      for (int i = 1; i < got_pc.size(); i++)
         if (got_pc[i] != got_pc[i-1] + 32'd4) n++;
      return n;
   endfunction

   function automatic int cs_in(input int a, input int b);
      int n = 0;
      foreach (got_cs_cyc[i])
         if (got_cs_cyc[i] >= a && got_cs_cyc[i] <= b) n++;
      return n;
   endfunction

   task automatic clear_logs();
      got_pc.delete();
      got_data.delete();
      got_addr.delete();
      got_cs_cyc.delete();
      got_v_cyc.delete();
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   initial begin : driver
      int s, lat;
      for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
      reset_n        = 1'b0;
      fetch_enable   = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      instr_ready    = 1'b0;
      run(3);

      // Reset release and first fetches
      fetch_enable = 1'b1;
      instr_ready  = 1'b1;
      clear_logs();
      reset_n = 1'b1;
      run(12);
      chk("first_addr", at(got_addr, 0), 32'h0);
      chk("first_pc", at(got_pc, 0), 32'h0);
      chk("second_pc", at(got_pc, 1), 32'h4);
      chk("third_pc", at(got_pc, 2), 32'h8);
      chk("fourth_pc", at(got_pc, 3), 32'hC);
      chk("first_data", at(got_data, 0), 32'h1000_0000);
      lat = (got_v_cyc.size() > 0 && got_cs_cyc.size() > 0) ? got_v_cyc[0] - got_cs_cyc[0] : -1;
      chk("first_latency", 32'(lat), 32'd2);

      // Backpressure stall
      clear_logs();
      run(3);
      instr_ready = 1'b0;
      s = cyc;
      run(5);
      instr_ready = 1'b1;
      run(8);
      chk("stall_no_issue", 32'(cs_in(s, s + 4)), 32'd0);
      chk("stall_contiguous", 32'(gaps()), 32'd0);
      chk("stall_delivered", 32'(got_pc.size() >= 8), 32'd1);

      // Redirect with a word in flight and the buffer occupied
      run(2);
      instr_ready    = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      clear_logs();
      tick();
      redirect_valid = 1'b0;
      instr_ready    = 1'b1;
      run(6);
      chk("redir_pc", at(got_pc, 0), 32'h0000_0100);
      chk("redir_data", at(got_data, 0), 32'h1000_0040);

      // Word-address wrap
      instr_ready    = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0FFC;
      clear_logs();
      tick();
      redirect_valid = 1'b0;
      instr_ready    = 1'b1;
      run(6);
      chk("wrap_addr0", at(got_addr, 0), 32'h3FF);
      chk("wrap_addr1", at(got_addr, 1), 32'h000);
      chk("wrap_pc0", at(got_pc, 0), 32'h0000_0FFC);
      chk("wrap_pc1", at(got_pc, 1), 32'h0000_1000);
      chk("wrap_data0", at(got_data, 0), 32'h1000_03FF);
      chk("wrap_data1", at(got_data, 1), 32'h1000_0000);

      // Asynchronous reset with buffered entries
      instr_ready = 1'b0;
      run(4);
      chk("pre_reset_valid", 32'(instr_valid), 32'h1);
      reset_n = 1'b0;
      #1;
      chk("async_reset_valid", 32'(instr_valid), 32'h0);
      chk("async_reset_cs", 32'(mem_chipselect), 32'h0);
      tick();
      reset_n     = 1'b1;
      instr_ready = 1'b1;
      clear_logs();
      run(10);
      chk("restart_addr", at(got_addr, 0), 32'(RESET_PC[11:2]));
      chk("restart_pc", at(got_pc, 0), RESET_PC);

      // fetch_enable pause and resume
      run(3);
      clear_logs();
      fetch_enable = 1'b0;
      repeat (4) begin
         #1;
         chk("paused_cs", 32'(mem_chipselect), 32'h0);
         tick();
      end
      fetch_enable = 1'b1;
      run(8);
      chk("pause_contiguous", 32'(gaps()), 32'd0);
      chk("pause_delivered", 32'(got_pc.size() >= 6), 32'd1);

      // Random traffic
      repeat (3000) begin
         fetch_enable   = ($urandom_range(0, 9) != 0);
         instr_ready    = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 24) == 0);
         redirect_pc    = $urandom();
         reset_n        = ($urandom_range(0, 499) != 0);
         tick();
      end
      reset_n        = 1'b1;
      redirect_valid = 1'b0;
      run(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
